// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem bus arbiter: FSM states, grant encodings,
// the default timeout read data and the memory map.
package iomem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_M0   = 2'b01;
    localparam gnt_t GNT_M1   = 2'b10;

    localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

    // Main RAM decode: an address is RAM when (addr & RAM_MASK) == RAM_BASE.
    localparam logic [31:0] RAM_BASE = 32'h4000_0000;
    localparam logic [31:0] RAM_MASK = 32'hFFF8_0000;

endpackage

// File: rtl/iomem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the master that was not served last wins.
module rr_pick2
    import iomem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,   // 1 = m1 was granted last
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        case (req_i)
            2'b01:   gnt_o = GNT_M0;
            2'b10:   gnt_o = GNT_M1;
            2'b11:   gnt_o = last_i ? GNT_M0 : GNT_M1;
            default: gnt_o = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/iomem_arbiter.sv
// Shares one iomem valid/ready bus between two masters, one transaction at a
// time, with round-robin fairness and a watchdog that ends unacknowledged transfers.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DFLT)
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH-1:0]   s_rdata,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e       state_q, state_d;
    gnt_t             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    gnt_t                  pick;
    logic                  owner_valid;
    logic                  wd_expire;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata_sel;

    rr_pick2 u_pick (
        .req_i  ({m1_valid, m0_valid}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    assign owner_valid = (gnt_q[0] && m0_valid) || (gnt_q[1] && m1_valid);
    // The counter holds completed stall cycles, so the Nth stall cycle is the
    // one in which the transfer is terminated.
    assign wd_expire   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        s_valid   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        done      = 1'b0;
        timeout_o = 1'b0;
        rdata_sel = s_rdata;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick != GNT_NONE) begin
                    gnt_d   = pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_addr  = gnt_q[1] ? m1_addr  : m0_addr;
                s_wdata = gnt_q[1] ? m1_wdata : m0_wdata;
                s_wstrb = gnt_q[1] ? m1_wstrb : m0_wstrb;
                if (!owner_valid) begin
                    // Master withdrew its request: abandon silently.
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                    cnt_d   = '0;
                end else if (s_ready) begin
                    s_valid = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                    last_d  = gnt_q[1];
                    cnt_d   = '0;
                end else if (wd_expire) begin
                    done      = 1'b1;
                    timeout_o = 1'b1;
                    rdata_sel = ERR_DATA;
                    state_d   = ST_IDLE;
                    gnt_d     = GNT_NONE;
                    last_d    = gnt_q[1];
                    cnt_d     = '0;
                end else begin
                    s_valid = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase

        // A reset cycle must never complete a transfer.
        if (!resetn) begin
            s_valid   = 1'b0;
            done      = 1'b0;
            timeout_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m0_ready = done && gnt_q[0];
    assign m1_ready = done && gnt_q[1];
    assign m0_rdata = m0_ready ? rdata_sel : '0;
    assign m1_rdata = m1_ready ? rdata_sel : '0;
    assign grant_o  = gnt_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_iomem_arbiter;

    localparam int TO = 16;
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mv[2];
    logic [31:0] ma[2];
    logic [31:0] mw[2];
    logic [3:0]  ms[2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    iomem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(mv[0]), .m0_ready(m0_ready), .m0_wstrb(ms[0]), .m0_addr(ma[0]),
        .m0_wdata(mw[0]), .m0_rdata(m0_rdata),
        .m1_valid(mv[1]), .m1_ready(m1_ready), .m1_wstrb(ms[1]), .m1_addr(ma[1]),
        .m1_wdata(mw[1]), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // ---------------- memories ----------------
    logic [31:0] ram [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          wr_count [logic [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ram[a] = d;
        ref_mem[a] = d;
    endtask

    // ---------------- slave responder ----------------
    // sl_age counts cycles since s_valid was first seen; ready when it reaches sl_delay.
    int sl_mode = 0;      // 0 = RAM, 1 = never answers
    int sl_fixed = 1;
    int sl_cfg = 1;
    int sl_delay = 1;
    int sl_age = -1;

    initial begin
        forever begin
            @(posedge clk); #2;
            s_ready = (sl_mode == 0) && (sl_age >= 1) && (sl_age == sl_delay);
            s_rdata = s_ready ? ram_rd(s_addr) : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (s_ready && s_valid && s_wstrb != 4'h0) begin
            ram[s_addr] = merge(ram_rd(s_addr), s_wdata, s_wstrb);
            wr_count[s_addr] = (wr_count.exists(s_addr) ? wr_count[s_addr] : 0) + 1;
        end
        if (!resetn || grant_o == 2'b00 || s_ready || timeout_o) sl_age = -1;
        else if (sl_age >= 0) sl_age++;
        else if (s_valid) begin
            sl_age = 1;
            if (sl_fixed != 0) sl_delay = sl_cfg;
            else begin
                case ($urandom_range(0, 5))
                    0: sl_delay = 15;
                    1: sl_delay = 20;
                    default: sl_delay = $urandom_range(1, 4);
                endcase
            end
        end
    end

    // ---------------- monitor + reference model + compare ----------------
    int   mo = -1;        // current owner, -1 when idle
    int   mage = 0;       // BUSY cycles already spent without completion
    int   mlast = 1;      // master served most recently
    logic e_sv, e_to, e_done;
    logic e_rdy[2];
    logic [31:0] e_rd[2];
    logic [1:0]  e_gnt;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_st;

    logic [1:0] prev_gnt = 2'b00;
    logic       prev_sv = 1'b0;
    int         sv_rise[2] = '{0, 0};
    int         rdy_cnt[2] = '{0, 0};
    int         to_cnt = 0;
    int         to_cyc = -1;
    logic [1:0] gnt_log[$];

    always @(negedge clk) begin
        if (grant_o != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(grant_o);
        if (s_valid && !prev_sv) sv_rise[grant_o[1] ? 1 : 0] = cyc;
        if (m0_ready) rdy_cnt[0]++;
        if (m1_ready) rdy_cnt[1]++;
        if (timeout_o) begin to_cnt++; to_cyc = cyc; end
        prev_gnt = grant_o;
        prev_sv  = s_valid;

        e_sv = 1'b0; e_to = 1'b0; e_done = 1'b0;
        e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
        e_rd[0] = 32'h0; e_rd[1] = 32'h0;
        e_gnt = 2'b00; e_addr = 32'h0; e_wd = 32'h0; e_st = 4'h0;
        if (mo >= 0) begin
            e_gnt  = (mo == 0) ? 2'b01 : 2'b10;
            e_addr = ma[mo]; e_wd = mw[mo]; e_st = ms[mo];
            if (mv[mo] && resetn) begin
                e_to      = !s_ready && (mage == TO - 1);
                e_done    = s_ready || e_to;
                e_sv      = !e_to;
                e_rdy[mo] = e_done;
                e_rd[mo]  = e_done ? (s_ready ? s_rdata : ERRV) : 32'h0;
            end
        end

        chk("grant",    grant_o,   e_gnt);
        chk("s_valid",  s_valid,   e_sv);
        chk("s_addr",   s_addr,    e_addr);
        chk("s_wdata",  s_wdata,   e_wd);
        chk("s_wstrb",  s_wstrb,   e_st);
        chk("timeout",  timeout_o, e_to);
        chk("m0_ready", m0_ready,  e_rdy[0]);
        chk("m1_ready", m1_ready,  e_rdy[1]);
        chk("m0_rdata", m0_rdata,  e_rd[0]);
        chk("m1_rdata", m1_rdata,  e_rd[1]);

        // End-to-end data: reads must see the latest completed write to that address.
        if (e_done && s_ready) begin
            if (ms[mo] == 4'h0) chk("e2e_rdata", mo ? m1_rdata : m0_rdata, ref_rd(ma[mo]));
            else ref_mem[ma[mo]] = merge(ref_rd(ma[mo]), mw[mo], ms[mo]);
        end

        if (!resetn) begin
            mo = -1; mage = 0; mlast = 1;
        end else if (mo < 0) begin
            if (mv[0] && mv[1]) mo = 1 - mlast;
            else if (mv[0]) mo = 0;
            else if (mv[1]) mo = 1;
            mage = 0;
        end else if (!mv[mo]) begin
            mo = -1;
        end else if (e_done) begin
            mlast = mo;
            mo = -1;
        end else begin
            mage++;
        end
    end

    // ---------------- master driver tasks ----------------
    task automatic do_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, output logic [31:0] rd,
                          output int rc, output int tc);
        @(posedge clk); #1;
        mv[m] = 1'b1; ma[m] = a; mw[m] = d; ms[m] = st;
        tc = cyc; rd = 32'h0; rc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ready : m1_ready) begin
                rd = (m == 0) ? m0_rdata : m1_rdata;
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            checks++; failures++;
            $display("FAIL txn_wait m%0d addr=%h no ready within bound", m, a);
        end
    endtask

    task automatic release_m(input int m);
        @(posedge clk); #1;
        mv[m] = 1'b0; ma[m] = 32'h0; mw[m] = 32'h0; ms[m] = 4'h0;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [31:0] a, rd;
        logic [3:0]  st;
        int rc, tc;
        for (int i = 0; i < n; i++) begin
            a  = 32'h4000_0000 + 32'($urandom_range(0, 15) << 2);
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_txn(m, a, $urandom, st, rd, rc, tc);
            if ($urandom_range(0, 2) == 0) begin
                release_m(m);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        release_m(m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd0, rd1;
        int rc0, rc1, tc0, tc1, to_before, rdy_before;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; ma[m] = 32'h0; mw[m] = 32'h0; ms[m] = 4'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_ready", {m1_ready, m0_ready, timeout_o}, 3'b000);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single read, 1-cycle RAM.
        preload(32'h4000_0010, 32'h1234_5678);
        sl_mode = 0; sl_fixed = 1; sl_cfg = 1;
        rdy_before = rdy_cnt[1];
        do_txn(0, 32'h4000_0010, 32'h0, 4'h0, rd0, rc0, tc0);
        release_m(0);
        chk("single_rdata", rd0, 32'h1234_5678);
        chk("single_ready_cyc", rc0, tc0 + 2);
        chk("single_svalid_cyc", sv_rise[0], tc0 + 1);
        chk("single_m1_quiet", rdy_cnt[1], rdy_before);

        // Tie straight after reset: m0 first, m1 two cycles after m0's ready.
        do_reset();
        preload(32'h4000_0020, 32'h0000_2020);
        preload(32'h4000_0024, 32'h0000_2424);
        fork
            begin do_txn(0, 32'h4000_0020, 32'h0, 4'h0, rd0, rc0, tc0); release_m(0); end
            begin do_txn(1, 32'h4000_0024, 32'h0, 4'h0, rd1, rc1, tc1); release_m(1); end
        join
        chk("tie_m0_first", rc0 < rc1, 1'b1);
        chk("tie_m1_svalid", sv_rise[1], rc0 + 2);
        chk("tie_m1_rdata", rd1, 32'h0000_2424);

        // Continuous contention: 8 writes each, strictly alternating.
        gnt_log.delete();
        fork
            begin
                logic [31:0] r; int c, t;
                for (int i = 0; i < 8; i++)
                    do_txn(0, 32'h4000_0100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, r, c, t);
                release_m(0);
            end
            begin
                logic [31:0] r; int c, t;
                for (int i = 0; i < 8; i++)
                    do_txn(1, 32'h4000_0200 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, r, c, t);
                release_m(1);
            end
        join
        @(negedge clk);
        chk("cont_grants", gnt_log.size(), 16);
        for (int i = 0; i < gnt_log.size(); i++)
            chk("cont_order", gnt_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        for (int i = 0; i < 8; i++) begin
            chk("cont_ram_m0", ram_rd(32'h4000_0100 + 32'(4 * i)), 32'hA0 + 32'(i));
            chk("cont_ram_m1", ram_rd(32'h4000_0200 + 32'(4 * i)), 32'hB0 + 32'(i));
            chk("cont_wr_once_m0", wr_count[32'h4000_0100 + 32'(4 * i)], 1);
            chk("cont_wr_once_m1", wr_count[32'h4000_0200 + 32'(4 * i)], 1);
        end

        // Watchdog on an unmapped address with a silent slave.
        sl_mode = 1;
        do_txn(1, 32'h1000_0000, 32'h0, 4'h0, rd1, rc1, tc1);
        release_m(1);
        chk("to_rdata", rd1, ERRV);
        chk("to_ready_cyc", rc1, sv_rise[1] + TO - 1);
        chk("to_pulse_cyc", to_cyc, rc1);
        @(negedge clk);
        chk("to_idle", grant_o, 2'b00);

        // s_ready lands in the final watchdog cycle: real data, no timeout.
        sl_mode = 0; sl_cfg = 15;
        preload(32'h4000_0040, 32'hC011_1DE0);
        to_before = to_cnt;
        do_txn(0, 32'h4000_0040, 32'h0, 4'h0, rd0, rc0, tc0);
        release_m(0);
        chk("coll_rdata", rd0, 32'hC011_1DE0);
        chk("coll_no_timeout", to_cnt, to_before);
        chk("coll_ready_cyc", rc0, sv_rise[0] + TO - 1);

        // Granted master withdraws: no ready, fairness state unchanged (m0 served last).
        sl_mode = 1;
        rdy_before = rdy_cnt[1];
        @(posedge clk); #1;
        mv[1] = 1'b1; ma[1] = 32'h4000_0050; ms[1] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        mv[1] = 1'b0; ma[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("drop_no_ready", rdy_cnt[1], rdy_before);
        chk("drop_idle", grant_o, 2'b00);
        sl_mode = 0; sl_cfg = 1;
        fork
            begin do_txn(0, 32'h4000_0020, 32'h0, 4'h0, rd0, rc0, tc0); release_m(0); end
            begin do_txn(1, 32'h4000_0024, 32'h0, 4'h0, rd1, rc1, tc1); release_m(1); end
        join
        chk("drop_tie_m1_first", rc1 < rc0, 1'b1);

        // Reset two cycles into BUSY with a 4-cycle RAM.
        sl_cfg = 4;
        rdy_before = rdy_cnt[0];
        @(posedge clk); #1;
        mv[0] = 1'b1; ma[0] = 32'h4000_0010; ms[0] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        mv[0] = 1'b0; ma[0] = 32'h0;
        @(negedge clk);
        chk("rst_mid_grant", grant_o, 2'b00);
        chk("rst_mid_outs", {s_valid, m0_ready, m1_ready, timeout_o}, 4'b0000);
        chk("rst_mid_no_ready", rdy_cnt[0], rdy_before);
        sl_cfg = 1;
        fork
            begin do_txn(0, 32'h4000_0020, 32'h0, 4'h0, rd0, rc0, tc0); release_m(0); end
            begin do_txn(1, 32'h4000_0024, 32'h0, 4'h0, rd1, rc1, tc1); release_m(1); end
        join
        chk("rst_tie_m0_first", rc0 < rc1, 1'b1);

        // Randomized traffic with random slave latency, including timeouts and collisions.
        sl_fixed = 0;
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit reached at cyc=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
